// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel button conditioner.
// Counter widths are derived per instance from the timing parameters via width_for().
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int unsigned SYNC_STAGES = 32'd2;
    localparam int unsigned STATE_W     = $bits(rep_state_t);

    // Bits needed for a counter that must hold 0..max_value (never narrower than 1).
    function automatic int unsigned width_for(input int unsigned max_value);
        if (max_value <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(max_value + 32'd1);
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-based stability filter and
// typematic repeat FSM. All outputs come straight from flops.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS  = 32'd10,
    parameter int unsigned REPEAT_EN     = 32'd1,
    parameter int unsigned REPEAT_DELAY  = 32'd500,
    parameter int unsigned REPEAT_PERIOD = 32'd100,
    parameter int unsigned ACTIVE_LOW    = 32'd0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W   = width_for(STABLE_TICKS);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W  = width_for(RPT_MAX - 32'd1);

    localparam logic              INVERT      = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_TICKS - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 32'd1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(32'd1);
    localparam logic [RCNT_W-1:0] RCNT_ZERO   = RCNT_W'(32'd0);

    logic              sync1_r;
    logic              sync2_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              level_r;
    logic              press_r;
    logic              release_r;
    logic              accept_s;
    logic              accept_press_s;
    logic              accept_release_s;
    rep_state_t        state_r;
    rep_state_t        state_nxt_s;
    logic [RCNT_W-1:0] rcnt_r;
    logic [RCNT_W-1:0] rcnt_nxt_s;
    logic              fire_s;
    logic              repeat_r;

    // Synchroniser: reset value 0 means "released" regardless of pin polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= button ^ INVERT;
            sync2_r <= sync1_r;
        end
    end

    // Stability filter: any cycle agreeing with level restarts the count.
    always_comb begin
        accept_s  = 1'b0;
        cnt_nxt_s = cnt_r;
        if (sync2_r == level_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (tick) begin
            if (cnt_r == CNT_LAST) begin
                accept_s  = 1'b1;
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    assign accept_press_s   = accept_s &  sync2_r;
    assign accept_release_s = accept_s & ~sync2_r;

    // Debounced level and its one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            level_r   <= accept_s ? sync2_r : level_r;
            press_r   <= accept_press_s;
            release_r <= accept_release_s;
        end
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rcnt_r  <= RCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
        end
    end

    // Repeat FSM next state; an accepted release overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        if (REPEAT_EN == 32'd0 || accept_release_s) begin
            state_nxt_s = IDLE;
            rcnt_nxt_s  = RCNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_press_s) begin
                        state_nxt_s = DELAY;
                        rcnt_nxt_s  = RCNT_ZERO;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DELAY: begin
                    if (tick && rcnt_r == DELAY_LAST) begin
                        state_nxt_s = REPEAT;
                        rcnt_nxt_s  = RCNT_ZERO;
                    end else if (tick) begin
                        rcnt_nxt_s = rcnt_r + RCNT_ONE;
                    end else begin
                        rcnt_nxt_s = rcnt_r;
                    end
                end
                REPEAT: begin
                    if (tick && rcnt_r == PERIOD_LAST) begin
                        rcnt_nxt_s = RCNT_ZERO;
                    end else if (tick) begin
                        rcnt_nxt_s = rcnt_r + RCNT_ONE;
                    end else begin
                        rcnt_nxt_s = rcnt_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    rcnt_nxt_s  = RCNT_ZERO;
                end
            endcase
        end
    end

    // Repeat FSM output decode.
    always_comb begin
        fire_s = 1'b0;
        if (REPEAT_EN != 32'd0 && tick && !accept_release_s) begin
            case (state_r)
                DELAY:   fire_s = (rcnt_r == DELAY_LAST);
                REPEAT:  fire_s = (rcnt_r == PERIOD_LAST);
                default: fire_s = 1'b0;
            endcase
        end else begin
            fire_s = 1'b0;
        end
    end

    // Registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_r <= 1'b0;
        end else begin
            repeat_r <= fire_s;
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;
    assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: one shared tick prescaler driving CHANNELS
// independent debounce_channel instances.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 32'd4,
    parameter int unsigned TICK_DIV      = 32'd50000,
    parameter int unsigned STABLE_TICKS  = 32'd10,
    parameter int unsigned REPEAT_EN     = 32'd1,
    parameter int unsigned REPEAT_DELAY  = 32'd500,
    parameter int unsigned REPEAT_PERIOD = 32'd100,
    parameter int unsigned ACTIVE_LOW    = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int unsigned      DIV_W    = width_for(TICK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);

    logic [DIV_W-1:0] div_r;
    logic             tick_s;

    assign tick_s = (div_r == DIV_LAST);

    // Shared prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= DIV_ZERO;
        end else if (tick_s) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS  (STABLE_TICKS),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick_s),
            .button        (button[ch]),
            .level         (level[ch]),
            .press         (press[ch]),
            .release_pulse (release_pulse[ch]),
            .repeat_pulse  (repeat_pulse[ch])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: a segment table for level/pulse counts plus
// hand sequences for bounce, repeat timing, release priority, reset and polarity.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button;
    logic [1:0] level, press, release_pulse, repeat_pulse;
    logic [1:0] button_al;
    logic [1:0] level_al, press_al, release_al, repeat_al;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_TICKS(3), .REPEAT_EN(1),
        .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .level(level), .press(press),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    debounce_bank #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_TICKS(3), .REPEAT_EN(1),
        .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .button(button_al), .level(level_al), .press(press_al),
        .release_pulse(release_al), .repeat_pulse(repeat_al)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Segment record: drive btn for len cycles, then expect final level and per-channel pulse counts.
    typedef struct {
        logic [1:0] btn;
        int         len;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
    } vec_t;

    vec_t tbl [7];

    int al_watch = 1;
    int al_ev    = 0;
    always @(negedge clk) begin
        if (al_watch != 0 && (level_al != 2'b00 || press_al != 2'b00 ||
                              release_al != 2'b00 || repeat_al != 2'b00)) begin
            al_ev = al_ev + 1;
        end
    end

    int         np [2];
    int         nr [2];
    int         nt [2];
    int         coh;
    logic [1:0] prev;
    int         ev, ev1, found, lat, pr_at, q_gap, rel_off, rpt_at_rel, rpt_cnt;

    initial begin
        // Segments start on prescaler phase 1 so each accepted change lands 12 edges in.
        tbl[0] = '{btn: 2'b00, len: 16, lvl: 2'b00, prs: 2'b00, rel: 2'b00, rpt: 2'b00};
        tbl[1] = '{btn: 2'b01, len: 16, lvl: 2'b01, prs: 2'b01, rel: 2'b00, rpt: 2'b00};
        tbl[2] = '{btn: 2'b11, len: 16, lvl: 2'b11, prs: 2'b10, rel: 2'b00, rpt: 2'b01};
        tbl[3] = '{btn: 2'b10, len: 16, lvl: 2'b10, prs: 2'b00, rel: 2'b01, rpt: 2'b11};
        tbl[4] = '{btn: 2'b00, len: 16, lvl: 2'b00, prs: 2'b00, rel: 2'b10, rpt: 2'b10};
        tbl[5] = '{btn: 2'b11, len: 16, lvl: 2'b11, prs: 2'b11, rel: 2'b00, rpt: 2'b00};
        tbl[6] = '{btn: 2'b00, len: 16, lvl: 2'b00, prs: 2'b00, rel: 2'b11, rpt: 2'b00};

        rst_n     = 1'b0;
        button    = 2'b00;
        button_al = 2'b11;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            button = 2'(i + 1);
            check("reset_outputs", int'({level, press, release_pulse, repeat_pulse}), 0);
        end
        @(negedge clk);
        button = 2'b00;
        rst_n  = 1'b1;

        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("tick_phase_edge%0d", n), int'(dut.tick_s), ((n % 4) == 3) ? 1 : 0);
        end

        for (int e = 0; e < 7; e++) begin
            for (int c = 0; c < 2; c++) begin
                np[c] = 0; nr[c] = 0; nt[c] = 0;
            end
            coh    = 0;
            prev   = level;
            button = tbl[e].btn;
            for (int k = 0; k < tbl[e].len; k++) begin
                @(negedge clk);
                for (int c = 0; c < 2; c++) begin
                    np[c] += press[c] ? 1 : 0;
                    nr[c] += release_pulse[c] ? 1 : 0;
                    nt[c] += repeat_pulse[c] ? 1 : 0;
                    if (press[c] && !(level[c] && !prev[c])) coh++;
                    if (release_pulse[c] && !(!level[c] && prev[c])) coh++;
                end
                prev = level;
            end
            check($sformatf("tbl%0d_level", e), int'(level), int'(tbl[e].lvl));
            check($sformatf("tbl%0d_edge_coherent", e), coh, 0);
            for (int c = 0; c < 2; c++) begin
                check($sformatf("tbl%0d_press_ch%0d", e, c), np[c], int'(tbl[e].prs[c]));
                check($sformatf("tbl%0d_release_ch%0d", e, c), nr[c], int'(tbl[e].rel[c]));
                check($sformatf("tbl%0d_repeat_ch%0d", e, c), nt[c], int'(tbl[e].rpt[c]));
            end
        end

        // Bounce: 5 high / 5 low never survives three ticks.
        ev = 0; ev1 = 0;
        for (int r = 0; r < 20; r++) begin
            button[0] = 1'b1;
            repeat (5) begin
                @(negedge clk);
                ev  += (level[0] | press[0] | release_pulse[0]) ? 1 : 0;
                ev1 += (level[1] | press[1] | release_pulse[1]) ? 1 : 0;
            end
            button[0] = 1'b0;
            repeat (5) begin
                @(negedge clk);
                ev  += (level[0] | press[0] | release_pulse[0]) ? 1 : 0;
                ev1 += (level[1] | press[1] | release_pulse[1]) ? 1 : 0;
            end
        end
        check("bounce_quiet_ch0", ev, 0);
        check("bounce_quiet_ch1", ev1, 0);

        button[0] = 1'b1;
        found = 0; lat = 0; pr_at = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (level[0]) begin
                found = 1; lat = c; pr_at = press[0] ? 1 : 0;
            end
        end
        check("stable_accept_found", found, 1);
        check("stable_latency_11_14", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("press_with_level", pr_at, 1);

        // Typematic: first repeat 20 +/- 4 after press, then every 8.
        found = 0; lat = 0;
        for (int c = 1; c <= 40 && found == 0; c++) begin
            @(negedge clk);
            if (repeat_pulse[0]) begin
                found = 1; lat = c;
            end
        end
        check("first_repeat_found", found, 1);
        check("first_repeat_16_24", (lat >= 16 && lat <= 24) ? 1 : 0, 1);
        for (int p = 0; p < 2; p++) begin
            q_gap = 0;
            for (int c = 1; c <= 16 && q_gap == 0; c++) begin
                @(negedge clk);
                if (repeat_pulse[0]) q_gap = c;
            end
            check($sformatf("repeat_period_%0d", p), q_gap, 8);
        end

        // Drop 3 edges after a repeat so the release lands on the next due repeat (+16).
        @(negedge clk);
        @(negedge clk);
        button[0] = 1'b0;
        rel_off = 0; rpt_at_rel = 0; rpt_cnt = 0;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clk);
            rpt_cnt += repeat_pulse[0] ? 1 : 0;
            if (release_pulse[0] && rel_off == 0) begin
                rel_off    = c;
                rpt_at_rel = repeat_pulse[0] ? 1 : 0;
            end
        end
        check("aligned_release_offset", rel_off, 16);
        check("aligned_release_no_repeat", rpt_at_rel, 0);
        check("aligned_window_repeats", rpt_cnt, 1);
        ev = 0;
        repeat (40) begin
            @(negedge clk);
            ev += (repeat_pulse[0] | press[0] | release_pulse[0] | level[0]) ? 1 : 0;
        end
        check("quiet_after_release", ev, 0);

        // Reset while ch1 is held.
        button[1] = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (level[1]) found = 1;
        end
        check("ch1_held_level", found, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_level1", int'(level[1]), 0);
        check("async_reset_no_release", int'(release_pulse), 0);
        ev = 0;
        repeat (3) begin
            @(negedge clk);
            ev += ({level, press, release_pulse, repeat_pulse} != 8'd0) ? 1 : 0;
        end
        check("reset_hold_outputs", ev, 0);
        rst_n = 1'b1;
        found = 0; lat = 0; pr_at = 0; ev = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            ev += release_pulse[1] ? 1 : 0;
            if (press[1]) begin
                found = 1; lat = c; pr_at = level[1] ? 1 : 0;
            end
        end
        check("repress_found", found, 1);
        check("repress_latency_11_14", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("repress_level", pr_at, 1);
        check("repress_no_release", ev, 0);

        // Active-low instance: idle-high pins stay released; a low pin is a press.
        check("active_low_idle_quiet", al_ev, 0);
        al_watch     = 0;
        button_al[0] = 1'b0;
        found = 0; lat = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (level_al[0]) begin
                found = 1; lat = c;
            end
        end
        check("active_low_press_found", found, 1);
        check("active_low_latency_11_14", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
        check("active_low_ch1_released", int'(level_al[1]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
